// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_st_e;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One two-entry skid stage: main register drives the output, skid absorbs the
// beat accepted while downstream stalls. Ready depends only on local state.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 33,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_st_e         state;
  skid_st_e         state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             drain;

  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_nxt = ST_FULL;
        else if (drain && !accept) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (drain) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is a flop loaded with the decode of the next state, so upstream
  // never sees a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (CLEAR_DATA && (reset || flush)) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) main_q <= in_data;
        ST_ONE: begin
          if (accept && drain) main_q <= in_data;
          else if (accept)     skid_q <= in_data;
        end
        ST_FULL:  if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// DEPTH cascaded skid stages with valid/ready, flush and a held-beat counter;
// drop-in replacement for the fixed inter-stage pipeline registers.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 33,
  parameter int unsigned DEPTH      = 1,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OW = occ_w(DEPTH);

  logic [DEPTH:0]   valid_c;
  logic [DEPTH:0]   ready_c;
  logic [WIDTH-1:0] data_c [DEPTH+1];
  logic             in_xfer;
  logic             out_xfer;

  assign valid_c[0]     = in_valid;
  assign data_c[0]      = in_data;
  assign in_ready       = ready_c[0];
  assign out_valid      = valid_c[DEPTH];
  assign out_data       = data_c[DEPTH];
  assign ready_c[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH      (WIDTH),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (valid_c[k]),
      .in_ready  (ready_c[k]),
      .in_data   (data_c[k]),
      .out_valid (valid_c[k+1]),
      .out_ready (ready_c[k+1]),
      .out_data  (data_c[k+1])
    );
  end

  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

  occ_bound: assert property (@(posedge clk) disable iff (reset)
    32'(occupancy) <= 2 * DEPTH);

  data_hold: assert property (@(posedge clk) disable iff (reset || flush)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic: four instances (DEPTH 1..4, WIDTH 8, DEPTH 3 clears data),
// directed vector table, hand sequences and a randomized scoreboard run.
module tb_pipe_elastic;
  import pipe_pkg::*;

  localparam int unsigned NI = 4;

  logic          clk;
  logic          reset;
  logic [NI-1:0] flush_v;
  logic [NI-1:0] in_valid_v;
  logic [NI-1:0] in_ready_v;
  logic [NI-1:0] out_valid_v;
  logic [NI-1:0] out_ready_v;
  logic [7:0]    in_data_v  [NI];
  logic [7:0]    out_data_v [NI];
  logic [3:0]    occ_v      [NI];

  int checks;
  int errors;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DEP = g + 1;
    logic [occ_w(DEP)-1:0] occ;
    pipe_elastic #(
      .WIDTH      (8),
      .DEPTH      (DEP),
      .CLEAR_DATA (g == 2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_v[g]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_data  (out_data_v[g]),
      .occupancy (occ)
    );
    assign occ_v[g] = 4'(occ);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned d;
    logic        rst;
    logic        iv;
    logic [7:0]  din;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [7:0]  dout;
    logic        ir;
    logic [3:0]  occ;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int unsigned d, input logic rst, input logic iv,
                              input logic [7:0] din, input logic ordy, input logic fl,
                              input logic ov, input logic [7:0] dout, input logic ir,
                              input logic [3:0] occ, input string name);
    vec_t v;
    v.d = d; v.rst = rst; v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.dout = dout; v.ir = ir; v.occ = occ; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned d, input logic iv, input logic [7:0] din,
                       input logic ordy, input logic fl);
    in_valid_v[d]  = iv;
    in_data_v[d]   = din;
    out_ready_v[d] = ordy;
    flush_v[d]     = fl;
  endtask

  task automatic idle_all();
    for (int unsigned i = 0; i < NI; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int unsigned d, input logic ov,
                            input logic [7:0] dout, input logic ir, input logic [3:0] occ);
    check({tag, " out_valid"}, out_valid_v[d], ov);
    if (ov) check({tag, " out_data"}, out_data_v[d], dout);
    check({tag, " in_ready"}, in_ready_v[d], ir);
    check({tag, " occupancy"}, occ_v[d], occ);
  endtask

  task automatic random_run(input int unsigned d, input int unsigned beats);
    logic [7:0]  q[$];
    logic [7:0]  exp_d;
    logic        iv, ordy, fl, ix, ox;
    logic [7:0]  din;
    int unsigned got;
    int unsigned cyc;
    got = 0;
    cyc = 0;
    do_reset();
    while (got < beats && cyc < 20000) begin
      iv   = ($urandom_range(0, 3) != 0);
      din  = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 199) == 0);
      drive(d, iv, din, ordy, fl);
      ox = out_valid_v[d] && ordy;
      ix = iv && in_ready_v[d] && !fl;
      if (ox) begin
        check("rand beat expected", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          check("rand data", out_data_v[d], exp_d);
          got++;
        end
      end
      // A beat leaving in the flush cycle is delivered before the model is cleared.
      if (fl) q.delete();
      else if (ix) q.push_back(din);
      tick();
      cyc++;
      check("rand occupancy", occ_v[d], q.size());
      check("rand occ bound", (32'(occ_v[d]) <= 2 * (d + 1)), 1'b1);
    end
    check("rand cycle budget", (got >= beats), 1'b1);
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
    for (int unsigned i = 0; i < NI; i++) expect_out("initial reset", i, 1'b0, 8'h00, 1'b1, 4'd0);

    // DEPTH=1: stream 0x01..0x10, then drain
    add(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, "d1 reset");
    for (int unsigned i = 0; i < 16; i++)
      add(0, 0, 1, 8'(i + 1), 1, 0, 1, 8'(i + 1), 1, 1, "d1 stream");
    add(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, "d1 stream drain");
    // DEPTH=1: stall into FULL and recover
    add(0, 0, 1, 8'hC1, 0, 0, 1, 8'hC1, 1, 1, "d1 stall a");
    add(0, 0, 1, 8'hC2, 0, 0, 1, 8'hC1, 0, 2, "d1 stall b");
    add(0, 0, 1, 8'hC3, 0, 0, 1, 8'hC1, 0, 2, "d1 stall c");
    add(0, 0, 1, 8'hC3, 1, 0, 1, 8'hC2, 1, 1, "d1 stall d");
    add(0, 0, 1, 8'hC3, 1, 0, 1, 8'hC3, 1, 1, "d1 stall e");
    add(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, "d1 stall f");
    // DEPTH=2: stall fill with 0xA0..0xA5, then release
    add(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, "d2 reset");
    add(1, 0, 1, 8'hA0, 0, 0, 0, 8'h00, 1, 1, "d2 fill 1");
    add(1, 0, 1, 8'hA1, 0, 0, 1, 8'hA0, 1, 2, "d2 fill 2");
    add(1, 0, 1, 8'hA2, 0, 0, 1, 8'hA0, 1, 3, "d2 fill 3");
    add(1, 0, 1, 8'hA3, 0, 0, 1, 8'hA0, 0, 4, "d2 fill 4");
    add(1, 0, 1, 8'hA4, 0, 0, 1, 8'hA0, 0, 4, "d2 fill blocked");
    add(1, 0, 1, 8'hA4, 1, 0, 1, 8'hA1, 0, 3, "d2 rel 1");
    add(1, 0, 1, 8'hA4, 1, 0, 1, 8'hA2, 1, 2, "d2 rel 2");
    add(1, 0, 1, 8'hA4, 1, 0, 1, 8'hA3, 1, 2, "d2 rel 3");
    add(1, 0, 1, 8'hA5, 1, 0, 1, 8'hA4, 1, 2, "d2 rel 4");
    add(1, 0, 0, 8'h00, 1, 0, 1, 8'hA5, 1, 1, "d2 rel 5");
    add(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, "d2 rel 6");

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        idle_all();
        reset = 1'b1;
      end else begin
        drive(vecs[i].d, vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      end
      tick();
      reset = 1'b0;
      expect_out(vecs[i].name, vecs[i].d, vecs[i].ov, vecs[i].dout, vecs[i].ir, vecs[i].occ);
    end
    idle_all();

    // DEPTH=1: accept and drain together in ONE, then flush with a beat leaving
    do_reset();
    drive(0, 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    expect_out("one hold", 0, 1'b1, 8'h11, 1'b1, 4'd1);
    drive(0, 1'b1, 8'h22, 1'b1, 1'b0);
    check("one delivered", out_data_v[0], 8'h11);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_out("one replace", 0, 1'b1, 8'h22, 1'b1, 4'd1);
    drive(0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    expect_out("flush w/ output", 0, 1'b0, 8'h00, 1'b1, 4'd0);

    // DEPTH=3, CLEAR_DATA: fill to 5, flush with 0x77 offered
    do_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      drive(2, 1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
      tick();
    end
    expect_out("d3 filled", 2, 1'b1, 8'h30, 1'b1, 4'd5);
    drive(2, 1'b1, 8'h77, 1'b0, 1'b1);
    tick();
    drive(2, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_out("d3 flushed", 2, 1'b0, 8'h00, 1'b1, 4'd0);
    check("d3 flushed data cleared", out_data_v[2], 8'h00);
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check("d3 no 0x77", out_valid_v[2], 1'b0);
    end
    idle_all();

    // DEPTH=2: reset while full, then 0x5A emerges after DEPTH cycles
    do_reset();
    for (int unsigned k = 0; k < 4; k++) begin
      drive(1, 1'b1, 8'(8'hE0 + k), 1'b0, 1'b0);
      tick();
    end
    expect_out("d2 full", 1, 1'b1, 8'hE0, 1'b0, 4'd4);
    drive(1, 1'b1, 8'hEE, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("d2 mid reset", 1, 1'b0, 8'h00, 1'b1, 4'd0);
    drive(1, 1'b1, 8'h5A, 1'b1, 1'b0);
    tick();
    drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_out("d2 5A t", 1, 1'b0, 8'h00, 1'b1, 4'd1);
    tick();
    expect_out("d2 5A t+1", 1, 1'b1, 8'h5A, 1'b1, 4'd1);
    tick();
    expect_out("d2 5A gone", 1, 1'b0, 8'h00, 1'b1, 4'd0);
    idle_all();

    for (int unsigned d = 0; d < NI; d++) random_run(d, 2500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
